gt1_rom_loader: RTL and testbench
=================================

Name: gt1_rom_loader

Overview:
- Downstream consumer of the Gigatron option ROM.
- Walks a GT1 image stored in that ROM (segment headers, payload, exec trailer) and copies every payload byte into Gigatron main RAM through a write handshake.
- Reports the program's start address when the copy is finished.
- Sits between the option ROM and the RAM arbiter; it is triggered from the OSD/loader control logic.

Parameters:
- ROM_LAST, 9866, index of the last valid ROM byte; a read beyond it is an overrun.
- ROM_AW, 15, ROM address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load from ROM byte 0
- rom_addr  out  ROM_AW  byte address to the option ROM
- rom_data  in  8  ROM data, combinational from rom_addr
- ram_we  out  1  write request
- ram_addr  out  16  RAM byte address
- ram_wdata  out  8  RAM write data
- ram_ready  in  1  arbiter accepts the write on an edge where ram_we=1
- ram_rdata  in  8  RAM read data at ram_addr; used only with the optional feature
- busy  out  1  load in progress
- done  out  1  sticky; load completed cleanly
- err  out  1  sticky; load aborted
- err_code  out  2  1=ROM overrun, 2=page crossing, 3=verify mismatch
- exec_addr  out  16  start address taken from the GT1 trailer

Behaviour:
- Reset: all outputs 0, FSM in IDLE, rom_addr=0.
- ROM read:
  - rom_addr is a register.
  - rom_data is sampled on the edge after rom_addr changes.
  - Each header/trailer byte costs 1 cycle.
  - rom_addr increments after each sample.
- States: IDLE, HI, LO, SZ, DATA, WR, VFY (optional), EXH, EXL, DONE, ERR.
- IDLE: on start, rom_addr←0, clear done/err/err_code, busy←1, go to HI.
  - start while busy is ignored.
  - start in DONE/ERR restarts the load.
- HI:
  - Sample the address high byte into seg_hi.
  - If the byte is 0x00 and at least one segment has completed, it is the terminator: go to EXH.
  - Otherwise go to LO. A page-0 first segment is therefore legal.
- LO: sample seg_lo, go to SZ.
- SZ:
  - Sample size; 0 means 256.
  - If seg_lo + size > 256, set err_code=2 and go to ERR.
  - Otherwise go to DATA.
- DATA:
  - Sample the payload byte.
  - ram_addr←{seg_hi,seg_lo}, ram_wdata←byte, ram_we←1, go to WR.
- WR:
  - Hold ram_addr/ram_wdata/ram_we stable until ram_we & ram_ready on an edge.
  - Then ram_we←0, seg_lo increments (8-bit), remaining count decrements.
  - If the count reaches 0, go to HI; else go to DATA.
  - Minimum throughput is 2 cycles per byte.
- EXH / EXL:
  - Sample exec_addr[15:8] then [7:0].
  - Then done←1, busy←0, go to DONE.
- ROM overrun:
  - Any sample with rom_addr > ROM_LAST gives err_code=1 and goes to ERR.
  - This check takes priority over decoding the byte.
- ERR: err←1, busy←0, ram_we←0; stay until start.
- DONE: hold; stay until start.
- ram_ready outside WR is ignored.
- reset mid-write drops ram_we on the same edge; no partial retry.

Optional Feature:
- Macro: GT1_LOADER_VERIFY_EN.
- Defined:
  - After each accepted write, enter VFY for one cycle with ram_we=0 and ram_addr held.
  - Compare ram_rdata to the written byte.
  - On a mismatch: err_code=3, go to ERR.
  - Throughput becomes 3 cycles per byte minimum.
- Undefined:
  - The VFY state is absent.
  - ram_rdata is unused.
  - err_code never takes the value 3.

Test Plan:
- Happy path: ROM = 02 00 03 AA BB CC 00 02 00 (and ram_ready tied 1); pulse start → three ram_we writes to 0x0200/0x0201/0x0202 with data AA/BB/CC; exec_addr=0x0200; done=1, err=0, busy=0.
- Size-0 segment: ROM = 08 00 00 followed by 256 bytes of 0x00..0xFF, then 00 08 00 → 256 writes, 0x0800..0x08FF, each with data equal to the low address byte; exec_addr=0x0800.
- ram_ready back-pressure: happy-path image with ram_ready low for 5 cycles on the second write → ram_addr=0x0201 and ram_wdata=BB held stable throughout; exactly 3 writes total.
- Page crossing: header 03 F0 20 → no writes; err=1, err_code=2.
- ROM overrun: set ROM_LAST=4 with the happy-path image → err=1, err_code=1 after at most 2 writes; ram_we=0 in ERR.
- Reset mid-load and restart: assert reset during WR → all outputs 0; pulse start afterwards → full reload completes. With GT1_LOADER_VERIFY_EN, forcing ram_rdata=0x00 while writing AA gives err_code=3.

Source files
------------

// File: rtl/gt1_rom_loader.sv
// GT1 image loader: walks segment headers/payload/exec trailer in the option ROM and copies payload into RAM.
// Optional read-back check of every written byte when GT1_LOADER_VERIFY_EN is defined.
module gt1_rom_loader #(
    parameter int ROM_LAST = 9866,
    parameter int ROM_AW   = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              ram_we,
    output logic [15:0]       ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic              ram_ready,
    input  logic [7:0]        ram_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [15:0]       exec_addr
);

    typedef enum logic [3:0] {
        S_IDLE, S_HI, S_LO, S_SZ, S_DATA, S_WR,
`ifdef GT1_LOADER_VERIFY_EN
        S_VFY,
`endif
        S_EXH, S_EXL, S_DONE, S_ERR
    } state_t;

    localparam logic [ROM_AW-1:0] LAST_A = ROM_AW'(ROM_LAST);

    state_t            state_q, state_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]        seg_hi_q, seg_hi_d;
    logic [7:0]        seg_lo_q, seg_lo_d;
    logic [8:0]        cnt_q, cnt_d;
    logic              seg_done_q, seg_done_d;
    logic              ram_we_q, ram_we_d;
    logic [15:0]       ram_addr_q, ram_addr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [15:0]       exec_addr_q, exec_addr_d;
    logic [8:0]        size9;
    logic              overrun;

`ifndef GT1_LOADER_VERIFY_EN
    logic unused_rdata;
    assign unused_rdata = ^ram_rdata;
`endif

    // A size byte of zero encodes a full 256-byte segment.
    assign size9   = (rom_data == 8'h00) ? 9'd256 : {1'b0, rom_data};
    assign overrun = (rom_addr_q > LAST_A);

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        seg_hi_d    = seg_hi_q;
        seg_lo_d    = seg_lo_q;
        cnt_d       = cnt_q;
        seg_done_d  = seg_done_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        exec_addr_d = exec_addr_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    rom_addr_d = '0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    err_code_d = 2'd0;
                    busy_d     = 1'b1;
                    seg_done_d = 1'b0;
                    state_d    = S_HI;
                end
            end
            S_WR: begin
                if (ram_ready) begin
                    ram_we_d = 1'b0;
                    seg_lo_d = seg_lo_q + 8'd1;
                    cnt_d    = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) seg_done_d = 1'b1;
`ifdef GT1_LOADER_VERIFY_EN
                    state_d = S_VFY;
`else
                    state_d = (cnt_q == 9'd1) ? S_HI : S_DATA;
`endif
                end
            end
`ifdef GT1_LOADER_VERIFY_EN
            S_VFY: begin
                if (ram_rdata != ram_wdata_q) begin
                    err_d      = 1'b1;
                    busy_d     = 1'b0;
                    err_code_d = 2'd3;
                    state_d    = S_ERR;
                end else begin
                    state_d = (cnt_q == 9'd0) ? S_HI : S_DATA;
                end
            end
`endif
            default: begin
                // ROM-consuming states: the overrun check wins over decoding the byte.
                if (overrun) begin
                    err_d      = 1'b1;
                    busy_d     = 1'b0;
                    ram_we_d   = 1'b0;
                    err_code_d = 2'd1;
                    state_d    = S_ERR;
                end else begin
                    rom_addr_d = rom_addr_q + 1'b1;
                    case (state_q)
                        S_HI: begin
                            seg_hi_d = rom_data;
                            state_d  = (rom_data == 8'h00 && seg_done_q) ? S_EXH : S_LO;
                        end
                        S_LO: begin
                            seg_lo_d = rom_data;
                            state_d  = S_SZ;
                        end
                        S_SZ: begin
                            cnt_d = size9;
                            if (({2'b00, seg_lo_q} + {1'b0, size9}) > 10'd256) begin
                                err_d      = 1'b1;
                                busy_d     = 1'b0;
                                err_code_d = 2'd2;
                                state_d    = S_ERR;
                            end else begin
                                state_d = S_DATA;
                            end
                        end
                        S_DATA: begin
                            ram_addr_d  = {seg_hi_q, seg_lo_q};
                            ram_wdata_d = rom_data;
                            ram_we_d    = 1'b1;
                            state_d     = S_WR;
                        end
                        S_EXH: begin
                            exec_addr_d[15:8] = rom_data;
                            state_d           = S_EXL;
                        end
                        S_EXL: begin
                            exec_addr_d[7:0] = rom_data;
                            done_d           = 1'b1;
                            busy_d           = 1'b0;
                            state_d          = S_DONE;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rom_addr_q  <= '0;
            seg_done_q  <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
            exec_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            seg_done_q  <= seg_done_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            exec_addr_q <= exec_addr_d;
        end
    end

    // Segment bookkeeping is always written before it is read, so it needs no reset.
    always_ff @(posedge clk) begin
        seg_hi_q <= seg_hi_d;
        seg_lo_q <= seg_lo_d;
        cnt_q    <= cnt_d;
    end

    assign rom_addr  = rom_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign exec_addr = exec_addr_q;

endmodule

// File: tb/tb_gt1_rom_loader.sv
// Directed bench for gt1_rom_loader: happy path, 256-byte segment, back-pressure, errors, reset/restart.
module tb_gt1_rom_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, ram_ready, rd_force;
    logic [14:0] rom_addr, o_rom_addr;
    logic [7:0]  rom_data, o_rom_data;
    logic        ram_we, o_ram_we;
    logic [15:0] ram_addr, o_ram_addr;
    logic [7:0]  ram_wdata, o_ram_wdata, ram_rdata, o_ram_rdata;
    logic        busy, done, err, o_busy, o_done, o_err;
    logic [1:0]  err_code, o_err_code;
    logic [15:0] exec_addr, o_exec_addr;

    logic [7:0]  rom_mem [0:511];
    logic [7:0]  happy [9] = '{8'h02, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h02, 8'h00};

    function automatic logic [7:0] rom_rd(input logic [14:0] a);
        return (a < 15'd512) ? rom_mem[a[8:0]] : 8'h00;
    endfunction

    assign rom_data    = rom_rd(rom_addr);
    assign o_rom_data  = rom_rd(o_rom_addr);
    assign ram_rdata   = rd_force ? 8'h00 : ram_wdata;
    assign o_ram_rdata = o_ram_wdata;

    gt1_rom_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_ready(ram_ready), .ram_rdata(ram_rdata),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .exec_addr(exec_addr)
    );

    gt1_rom_loader #(.ROM_LAST(4)) dut_ovr (
        .clk(clk), .reset(reset), .start(start),
        .rom_addr(o_rom_addr), .rom_data(o_rom_data),
        .ram_we(o_ram_we), .ram_addr(o_ram_addr), .ram_wdata(o_ram_wdata),
        .ram_ready(ram_ready), .ram_rdata(o_ram_rdata),
        .busy(o_busy), .done(o_done), .err(o_err), .err_code(o_err_code), .exec_addr(o_exec_addr)
    );

    // Accepted-write log: a write is taken on the next rising edge if we & ready hold now.
    logic [15:0] wq_a [$];
    logic [7:0]  wq_d [$];
    int          ovr_cnt = 0;
    always @(negedge clk) begin
        if (ram_we && ram_ready) begin
            wq_a.push_back(ram_addr);
            wq_d.push_back(ram_wdata);
        end
        if (o_ram_we && ram_ready) ovr_cnt++;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input int max);
        for (int i = 0; i < max && !(done || err); i++) tick();
        chk("end_reached", 32'(done || err), 32'd1);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 512; i++) rom_mem[i] = 8'h00;
    endtask

    task automatic load_happy();
        clear_rom();
        for (int i = 0; i < 9; i++) rom_mem[i] = happy[i];
    endtask

    task automatic chk_happy_writes(input string tag, input int base);
        chk({tag, "_nwr"}, 32'(wq_a.size() - base), 32'd3);
        if (wq_a.size() - base >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk({tag, "_addr"}, 32'(wq_a[base+i]), 32'h0200 + 32'(i));
                chk({tag, "_data"}, 32'(wq_d[base+i]), 32'(happy[3+i]));
            end
        end
    endtask

    initial begin
        int base;
        int obase;
        int hold_bad;
        bit found;

        reset = 1'b1; start = 1'b0; ram_ready = 1'b1; rd_force = 1'b0;
        clear_rom();
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_romaddr", 32'(rom_addr), 32'd0);
        chk("rst_exec", 32'(exec_addr), 32'd0);
        reset = 1'b0;
        tick();

        // Happy path
        load_happy();
        base = wq_a.size();
        pulse_start();
        chk("hp_busy_on", 32'(busy), 32'd1);
        wait_end(200);
        chk("hp_done", 32'(done), 32'd1);
        chk("hp_err", 32'(err), 32'd0);
        chk("hp_busy_off", 32'(busy), 32'd0);
        chk("hp_we_idle", 32'(ram_we), 32'd0);
        chk("hp_exec", 32'(exec_addr), 32'h0200);
        chk_happy_writes("hp", base);

        // 256-byte segment, with an ignored start pulse mid-load
        clear_rom();
        rom_mem[0] = 8'h08; rom_mem[1] = 8'h00; rom_mem[2] = 8'h00;
        for (int i = 0; i < 256; i++) rom_mem[3+i] = 8'(i);
        rom_mem[259] = 8'h00; rom_mem[260] = 8'h08; rom_mem[261] = 8'h00;
        base = wq_a.size();
        pulse_start();
        repeat (20) tick();
        pulse_start();
        wait_end(3000);
        chk("s0_done", 32'(done), 32'd1);
        chk("s0_err", 32'(err), 32'd0);
        chk("s0_exec", 32'(exec_addr), 32'h0800);
        chk("s0_nwr", 32'(wq_a.size() - base), 32'd256);
        if (wq_a.size() - base >= 256) begin
            for (int i = 0; i < 256; i++) begin
                chk("s0_addr", 32'(wq_a[base+i]), 32'h0800 + 32'(i));
                chk("s0_data", 32'(wq_d[base+i]), 32'(i));
            end
        end

        // Back-pressure on the second write
        load_happy();
        base = wq_a.size();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (ram_we && ram_addr == 16'h0201) found = 1'b1;
            else tick();
        end
        chk("bp_found", 32'(found), 32'd1);
        ram_ready = 1'b0;
        hold_bad = 0;
        repeat (5) begin
            tick();
            if (!(ram_we && ram_addr == 16'h0201 && ram_wdata == 8'hBB)) hold_bad++;
        end
        chk("bp_hold", 32'(hold_bad), 32'd0);
        ram_ready = 1'b1;
        wait_end(200);
        chk("bp_done", 32'(done), 32'd1);
        chk_happy_writes("bp", base);

        // Page crossing
        clear_rom();
        rom_mem[0] = 8'h03; rom_mem[1] = 8'hF0; rom_mem[2] = 8'h20;
        base = wq_a.size();
        pulse_start();
        wait_end(50);
        chk("pc_err", 32'(err), 32'd1);
        chk("pc_code", 32'(err_code), 32'd2);
        chk("pc_done", 32'(done), 32'd0);
        chk("pc_busy", 32'(busy), 32'd0);
        chk("pc_nwr", 32'(wq_a.size() - base), 32'd0);

        // ROM overrun on the ROM_LAST=4 instance
        load_happy();
        obase = ovr_cnt;
        pulse_start();
        wait_end(200);
        chk("ov_err", 32'(o_err), 32'd1);
        chk("ov_code", 32'(o_err_code), 32'd1);
        chk("ov_we", 32'(o_ram_we), 32'd0);
        chk("ov_busy", 32'(o_busy), 32'd0);
        chk("ov_done", 32'(o_done), 32'd0);
        chk("ov_nwr_le2", 32'((ovr_cnt - obase) <= 2), 32'd1);

        // Reset while a write is pending, then a full reload
        load_happy();
        ram_ready = 1'b0;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (ram_we) found = 1'b1;
            else tick();
        end
        chk("rm_in_wr", 32'(found), 32'd1);
        reset = 1'b1;
        tick();
        chk("rm_we", 32'(ram_we), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_done", 32'(done), 32'd0);
        chk("rm_err", 32'(err), 32'd0);
        chk("rm_romaddr", 32'(rom_addr), 32'd0);
        chk("rm_ramaddr", 32'(ram_addr), 32'd0);
        chk("rm_wdata", 32'(ram_wdata), 32'd0);
        chk("rm_exec", 32'(exec_addr), 32'd0);
        reset = 1'b0;
        ram_ready = 1'b1;
        tick();
        base = wq_a.size();
        pulse_start();
        wait_end(200);
        chk("rl_done", 32'(done), 32'd1);
        chk("rl_exec", 32'(exec_addr), 32'h0200);
        chk_happy_writes("rl", base);

`ifdef GT1_LOADER_VERIFY_EN
        // Read-back mismatch on the first written byte
        load_happy();
        rd_force = 1'b1;
        base = wq_a.size();
        pulse_start();
        wait_end(200);
        chk("vf_err", 32'(err), 32'd1);
        chk("vf_code", 32'(err_code), 32'd3);
        chk("vf_nwr", 32'(wq_a.size() - base), 32'd1);
        rd_force = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
